multi_tone_generator: RTL and testbench
=======================================

// Module: multi_tone_generator
// PURPOSE
//  Parametrised successor to the single-channel period-in-ns tick generator.
//  Drives CHANNELS independent tone channels for the melody/audio path.
//  Each channel has a programmable period and duty in ns, a one-cycle tick
//  per period and a square/PWM wave output. A mix output counts the channels
//  whose wave is currently high; it feeds the buzzer/DAC stage.
//  Config writes are glitch-free: new period/duty apply only at period wrap.
// PARAMETERS
//  CHANNELS  4   number of tone channels (1..16)
//  PERIOD_W  32  width of period/duty/phase words, in ns
//  CLK_NS    20  clk period in ns; phase increment per cycle
// PORTS
//  clk         in   1                  system clock; all logic on posedge
//  rst_n       in   1                  synchronous, active-low reset
//  cfg_we      in   1                  config write strobe, one cycle
//  cfg_ch      in   max(1,clog2(CHANNELS))  target channel for the write
//  cfg_en      in   1                  channel enable written with cfg_we
//  cfg_period  in   PERIOD_W           tone period in ns; 0 = muted
//  cfg_duty    in   PERIOD_W           high time in ns, per period
//  wave        out  CHANNELS           per-channel PWM/square output, registered
//  tick        out  CHANNELS           per-channel 1-cycle pulse at period wrap
//  mix         out  clog2(CHANNELS+1)  popcount of wave, registered
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low. Clock port is
//  clk; reset port is rst_n.
//  Reset (rst_n=0 at posedge) clears all of the following: en, ph, shadow and
//  active period/duty, wave, tick and mix. Reset mid-tone takes effect on the
//  next edge.
//  Per-channel state:
//   - en
//   - ph: phase counter
//   - per_sh, duty_sh: shadow registers
//   - per_act, duty_act: active registers
//  Write: cfg_we=1 with cfg_ch<CHANNELS updates en, per_sh and duty_sh of
//  that channel. cfg_ch>=CHANNELS is ignored with no state change.
//  Channel is enabled and was already enabled: the write touches only the
//  shadow registers. The active values change at the next wrap.
//  Channel goes from disabled to enabled: per_act/duty_act load directly from
//  cfg_*, ph is cleared to 0, and counting starts on the following cycle.
//  Channel is disabled (cfg_en=0): next cycle ph=0, and wave, tick and the
//  channel's mix contribution are all 0.
//  Counting, every cycle for an enabled channel with per_act!=0:
//   - nxt = ph + CLK_NS, computed at PERIOD_W+1 bits (no overflow wrap).
//   - nxt >= per_act (wrap): ph<=0, tick<=1, per_act<=per_sh,
//     duty_act<=duty_sh.
//   - otherwise: ph<=nxt, tick<=0.
//  Tick spacing is ceil(per_act/CLK_NS) cycles. per_act<=CLK_NS gives a tick
//  every cycle.
//  wave <= (ph < duty_act), registered, so it lags ph by one cycle.
//   - duty_act=0: wave is always 0.
//   - duty_act >= per_act: wave is always 1.
//  per_act=0 while enabled means muted: ph holds 0, tick=0, wave=0.
//   - A later write to per_sh never takes effect by itself, because no wrap
//     occurs.
//   - Software must re-enable the channel (write en=0 then en=1) to load it.
//  mix <= popcount of the wave vector's next value, so mix and wave update on
//  the same edge.
//  Simultaneous write and wrap on the same channel: the wrap loads the old
//  per_sh/duty_sh. The new shadow values apply at the following wrap.
//  Channels are fully independent; there is no cross-channel arbitration.
// TESTING
//  1. CLK_NS=20. Write ch0 en=1, per=100, duty=40.
//     -> tick[0] every 5 cycles; wave[0] high 2 of 5 cycles; mix toggles 0/1.
//  2. Ch0 running per=100. Write per=200, duty=100 mid-period.
//     -> current period still 5 cycles, then ticks every 10 cycles with
//        5 cycles high; no runt pulse.
//  3. Ch0..ch3 all enabled, per=100, duty=100 (>= period).
//     -> wave=4'b1111 constant, mix=4; disable ch2 -> next cycle wave[2]=0,
//        mix=3.
//  4. per=0 with en=1 -> tick and wave stay 0. per=10 (< CLK_NS) -> tick
//     high every cycle. cfg_ch=7 with CHANNELS=4 -> no state change.
//  5. PERIOD_W=32, per=32'hFFFF_FFF0, ph near the top.
//     -> nxt compare has no overflow; wrap at ph+20 >= per, ph returns to 0.
//  6. Pull rst_n low for 1 cycle mid-tone.
//     -> next edge: all outputs 0, all channels disabled; a write is needed
//        to restart.

Source files
------------

// File: rtl/multi_tone_generator.sv
// Multi-channel tone generator: per-channel programmable period/duty in ns,
// one-cycle tick at each period wrap, PWM wave and a popcount mix output.
module multi_tone_generator #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PERIOD_W = 32,
  parameter int unsigned CLK_NS   = 20,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned MIX_W   = $clog2(CHANNELS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic                cfg_en,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_duty,
  output logic [CHANNELS-1:0] wave,
  output logic [CHANNELS-1:0] tick,
  output logic [MIX_W-1:0]    mix
);

  localparam logic [PERIOD_W:0] INC = (PERIOD_W + 1)'(CLK_NS);

  logic [CHANNELS-1:0]               en_q, en_d, tick_d, wave_d;
  logic [CHANNELS-1:0][PERIOD_W-1:0] ph_q, ph_d;
  logic [CHANNELS-1:0][PERIOD_W-1:0] psh_q, psh_d, dsh_q, dsh_d;
  logic [CHANNELS-1:0][PERIOD_W-1:0] pact_q, pact_d, dact_q, dact_d;
  logic [MIX_W-1:0]                  mix_d;
  logic [PERIOD_W:0]                 nxt;
  logic                              wr;

  always_comb begin
    en_d   = en_q;
    ph_d   = ph_q;
    psh_d  = psh_q;
    dsh_d  = dsh_q;
    pact_d = pact_q;
    dact_d = dact_q;
    tick_d = '0;
    wave_d = '0;
    mix_d  = '0;
    nxt    = '0;
    wr     = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr = cfg_we && (32'(cfg_ch) == i);
      if (wr) begin
        en_d[i]  = cfg_en;
        psh_d[i] = cfg_period;
        dsh_d[i] = cfg_duty;
      end
      if (wr && cfg_en && !en_q[i]) begin
        pact_d[i] = cfg_period;
        dact_d[i] = cfg_duty;
        ph_d[i]   = '0;
      end else if (!en_q[i] || (wr && !cfg_en) || (pact_q[i] == '0)) begin
        ph_d[i] = '0;
      end else begin
        // Wrap reloads from the shadow values as they stood before any
        // same-cycle write, so a concurrent write lands one period later.
        nxt       = {1'b0, ph_q[i]} + INC;
        wave_d[i] = (ph_q[i] < dact_q[i]);
        if (nxt >= {1'b0, pact_q[i]}) begin
          ph_d[i]   = '0;
          tick_d[i] = 1'b1;
          pact_d[i] = psh_q[i];
          dact_d[i] = dsh_q[i];
        end else begin
          ph_d[i] = nxt[PERIOD_W-1:0];
        end
      end
      mix_d = mix_d + MIX_W'(wave_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q   <= '0;
      ph_q   <= '0;
      psh_q  <= '0;
      dsh_q  <= '0;
      pact_q <= '0;
      dact_q <= '0;
      wave   <= '0;
      tick   <= '0;
      mix    <= '0;
    end else begin
      en_q   <= en_d;
      ph_q   <= ph_d;
      psh_q  <= psh_d;
      dsh_q  <= dsh_d;
      pact_q <= pact_d;
      dact_q <= dact_d;
      wave   <= wave_d;
      tick   <= tick_d;
      mix    <= mix_d;
    end
  end

endmodule

// File: tb/tb_multi_tone_generator.sv
// Directed bench for multi_tone_generator: a 4-channel/32-bit instance and a
// 3-channel/8-bit instance for out-of-range channel and phase-overflow cases.
module tb_multi_tone_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, cfg_en;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_period, cfg_duty;
  logic [3:0]  wave, tick;
  logic [2:0]  mix;

  logic        b_we, b_en;
  logic [1:0]  b_ch;
  logic [7:0]  b_per, b_duty;
  logic [2:0]  b_wave, b_tick;
  logic [1:0]  b_mix;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multi_tone_generator #(.CHANNELS(4), .PERIOD_W(32), .CLK_NS(20)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_en(cfg_en),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .wave(wave), .tick(tick), .mix(mix)
  );

  multi_tone_generator #(.CHANNELS(3), .PERIOD_W(8), .CLK_NS(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_we(b_we), .cfg_ch(b_ch), .cfg_en(b_en),
    .cfg_period(b_per), .cfg_duty(b_duty),
    .wave(b_wave), .tick(b_tick), .mix(b_mix)
  );

  typedef struct {
    logic        we;
    logic [1:0]  ch;
    logic        en;
    logic [31:0] per;
    logic [31:0] duty;
    logic [3:0]  w;
    logic [3:0]  t;
    logic [2:0]  m;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic we, input logic [1:0] ch, input logic en,
                              input logic [31:0] per, input logic [31:0] duty,
                              input logic [3:0] w, input logic [3:0] t, input logic [2:0] m);
    vec_t v;
    v.we = we; v.ch = ch; v.en = en; v.per = per; v.duty = duty;
    v.w = w; v.t = t; v.m = m;
    vt.push_back(v);
  endfunction

  function automatic void idle(input logic [3:0] w, input logic [3:0] t, input logic [2:0] m);
    add(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, w, t, m);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [1:0] ch, input logic en, input logic [31:0] per,
                      input logic [31:0] duty);
    cfg_we = 1'b1; cfg_ch = ch; cfg_en = en; cfg_period = per; cfg_duty = duty;
    step();
    cfg_we = 1'b0;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_en = 1'b0; cfg_period = '0; cfg_duty = '0;
    b_we = 1'b0; b_ch = '0; b_en = 1'b0; b_per = '0; b_duty = '0;

    // Tone at per=100/duty=40 (5-cycle period, 2 high), then a mid-period
    // rewrite to per=200/duty=100 that must only apply after the next wrap.
    add(1'b1, 2'd0, 1'b1, 32'd100, 32'd40, 4'h0, 4'h0, 3'd0);
    idle(4'h1, 4'h0, 3'd1); idle(4'h1, 4'h0, 3'd1);
    idle(4'h0, 4'h0, 3'd0); idle(4'h0, 4'h0, 3'd0);
    idle(4'h0, 4'h1, 3'd0);
    idle(4'h1, 4'h0, 3'd1); idle(4'h1, 4'h0, 3'd1);
    idle(4'h0, 4'h0, 3'd0); idle(4'h0, 4'h0, 3'd0);
    idle(4'h0, 4'h1, 3'd0);
    idle(4'h1, 4'h0, 3'd1);
    add(1'b1, 2'd0, 1'b1, 32'd200, 32'd100, 4'h1, 4'h0, 3'd1);
    idle(4'h0, 4'h0, 3'd0); idle(4'h0, 4'h0, 3'd0);
    idle(4'h0, 4'h1, 3'd0);
    for (int i = 0; i < 5; i++) idle(4'h1, 4'h0, 3'd1);
    for (int i = 0; i < 4; i++) idle(4'h0, 4'h0, 3'd0);
    idle(4'h0, 4'h1, 3'd0);
    idle(4'h1, 4'h0, 3'd1);

    step(); step();
    chk("reset_wave", 32'(wave), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_mix", 32'(mix), 32'h0);
    chk("reset_b_wave", 32'(b_wave), 32'h0);
    chk("reset_b_tick", 32'(b_tick), 32'h0);
    chk("reset_b_mix", 32'(b_mix), 32'h0);
    rst_n = 1'b1;

    foreach (vt[k]) begin
      cfg_we = vt[k].we; cfg_ch = vt[k].ch; cfg_en = vt[k].en;
      cfg_period = vt[k].per; cfg_duty = vt[k].duty;
      step();
      chk($sformatf("vec%0d_wave", k), 32'(wave), 32'(vt[k].w));
      chk($sformatf("vec%0d_tick", k), 32'(tick), 32'(vt[k].t));
      chk($sformatf("vec%0d_mix", k), 32'(mix), 32'(vt[k].m));
    end
    cfg_we = 1'b0;

    // Reset mid-tone: outputs clear on the next edge and stay clear.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_wave", 32'(wave), 32'h0);
    chk("midrst_tick", 32'(tick), 32'h0);
    chk("midrst_mix", 32'(mix), 32'h0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("postrst_wave", 32'(wave), 32'h0);
      chk("postrst_tick", 32'(tick), 32'h0);
    end

    // All channels with duty >= period: constant high, then disable ch2.
    for (int i = 0; i < 4; i++) wr_a(2'(i), 1'b1, 32'd100, 32'd100);
    step();
    for (int i = 0; i < 10; i++) begin
      chk("full_wave", 32'(wave), 32'hF);
      chk("full_mix", 32'(mix), 32'd4);
      step();
    end
    wr_a(2'd2, 1'b0, 32'd100, 32'd100);
    chk("dis2_wave", 32'(wave), 32'hB);
    chk("dis2_mix", 32'(mix), 32'd3);
    step();
    chk("dis2_wave_hold", 32'(wave), 32'hB);

    // Muted channel (per=0), shadow write that must not unmute, then per<CLK_NS.
    wr_a(2'd3, 1'b0, 32'd0, 32'd0);
    wr_a(2'd3, 1'b1, 32'd0, 32'd50);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mute_tick3", 32'(tick[3]), 32'h0);
      chk("mute_wave3", 32'(wave[3]), 32'h0);
    end
    wr_a(2'd3, 1'b1, 32'd100, 32'd40);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mute_sh_tick3", 32'(tick[3]), 32'h0);
      chk("mute_sh_wave3", 32'(wave[3]), 32'h0);
    end
    wr_a(2'd3, 1'b0, 32'd0, 32'd0);
    wr_a(2'd3, 1'b1, 32'd10, 32'd5);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("fast_tick3", 32'(tick[3]), 32'h1);
      chk("fast_wave3", 32'(wave[3]), 32'h1);
    end

    // Out-of-range channel on the 3-channel instance must change nothing.
    b_we = 1'b1; b_ch = 2'd3; b_en = 1'b1; b_per = 8'd100; b_duty = 8'd40;
    step();
    b_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("oor_b_wave", 32'(b_wave), 32'h0);
      chk("oor_b_tick", 32'(b_tick), 32'h0);
      chk("oor_b_mix", 32'(b_mix), 32'h0);
    end

    // Period near the top of the 8-bit range: ph=240 -> nxt=260 must wrap.
    b_we = 1'b1; b_ch = 2'd0; b_en = 1'b1; b_per = 8'hFA; b_duty = 8'd128;
    step();
    b_we = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      cnt = 0;
      do begin
        step();
        cnt++;
      end while (!b_tick[0] && cnt < 40);
      chk($sformatf("ovf_period%0d", pass), 32'(cnt), 32'd13);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
